// File: rtl/morse_pkg.sv
// Shared Morse digit definitions: FSM states, symbol values and the digit table.
// Pure definitions, no latency; no flow control involved.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    // Index i holds the symbol pattern of digit i, first symbol in bit 4.
    localparam logic [9:0][4:0] DIGIT_PAT = {
        5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000,
        5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111
    };

    localparam logic [9:0][3:0] DIGIT_CODE = {
        4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
    };

endpackage

// File: rtl/morse_symbol_lut.sv
// Maps a 5-symbol Morse pattern to {legal, abcd} digit code.
// Purely combinational, zero latency; no backpressure.
module morse_symbol_lut
    import morse_pkg::*;
(
    input  logic [4:0] pattern_i,
    output logic       legal_o,
    output logic [3:0] digit_o
);

    always_comb begin
        legal_o = 1'b0;
        digit_o = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pattern_i == DIGIT_PAT[i]) begin
                legal_o = 1'b1;
                digit_o = DIGIT_CODE[i];
            end
        end
    end

endmodule

// File: rtl/morse_digit_decoder.sv
// Morse key stream to decimal digit decoder: times presses, collects 5 symbols, looks up the digit.
// Latency: valid/error 2 edges after the final release sample (+2 with MORSE_DEC_SYNC_EN, key synchronizer).
// No backpressure: valid/error are single-cycle pulses, a/b/c/d and m1..m5 hold until the next valid.
module morse_digit_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX    = 4,
    parameter int GAP_CYCLES = 12,
    parameter int CNT_W      = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic m1,
    output logic m2,
    output logic m3,
    output logic m4,
    output logic m5,
    output logic valid,
    output logic error
);

    localparam logic [CNT_W-1:0] DOT_LIM = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [4:0]       sym_q, sym_d;
    logic [3:0]       abcd_q, abcd_d;
    logic [4:0]       m_q, m_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic             key_s;
    logic             lut_legal;
    logic [3:0]       lut_digit;

`ifdef MORSE_DEC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], key};
    end

    assign key_s = sync_q[1];
`else
    assign key_s = key;
`endif

    morse_symbol_lut u_lut (
        .pattern_i (sym_q),
        .legal_o   (lut_legal),
        .digit_o   (lut_digit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (key_s) state_d = ST_MARK;
            ST_MARK:  if (!key_s) state_d = (idx_q == 3'd4) ? ST_DONE : ST_SPACE;
            ST_SPACE: begin
                if (key_s)                 state_d = ST_MARK;
                else if (cnt_q >= GAP_LIM) state_d = ST_IDLE;
            end
            ST_DONE:  state_d = key_s ? ST_MARK : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        abcd_d  = abcd_q;
        m_d     = m_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            ST_IDLE: if (key_s) cnt_d = CNT_ONE;
            ST_MARK: begin
                if (key_s) begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                end else begin
                    sym_d = {sym_q[3:0], (cnt_q >= DOT_LIM) ? DASH : DOT};
                    idx_d = idx_q + 3'd1;
                    cnt_d = CNT_ONE;
                end
            end
            ST_SPACE: begin
                if (key_s) begin
                    cnt_d = CNT_ONE;
                end else if (cnt_q >= GAP_LIM) begin
                    // Gap expired mid-character: drop the partial symbols.
                    error_d = 1'b1;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (lut_legal) begin
                    m_d     = sym_q;
                    abcd_d  = lut_digit;
                    valid_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
                idx_d = 3'd0;
                cnt_d = key_s ? CNT_ONE : '0;
            end
            default: begin
                idx_d = 3'd0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            sym_q   <= 5'd0;
            abcd_q  <= 4'd0;
            m_q     <= 5'd0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            abcd_q  <= abcd_d;
            m_q     <= m_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign {a, b, c, d}          = abcd_q;
    assign {m1, m2, m3, m4, m5}  = m_q;
    assign valid                 = valid_q;
    assign error                 = error_q;

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Randomized bench for morse_digit_decoder against a table-driven reference of Morse digits.
module tb_morse_digit_decoder;

    localparam int DOT_MAX    = 4;
    localparam int GAP_CYCLES = 12;
    localparam int CNT_W      = 8;
`ifdef MORSE_DEC_SYNC_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic key   = 1'b0;
    logic a, b, c, d, m1, m2, m3, m4, m5, valid, error;

    int n_cmp = 0;
    int n_bad = 0;
    int nv = 0, ne = 0, nboth = 0;
    int exp_nv = 0, exp_ne = 0;
    logic [3:0] exp_abcd = 4'd0;
    logic [4:0] exp_m    = 5'd0;

    // Digit i written as dots and dashes, first symbol leftmost.
    string REF [10] = '{"-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

    morse_digit_decoder #(
        .DOT_MAX    (DOT_MAX),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clock (clock), .reset (reset), .key (key),
        .a (a), .b (b), .c (c), .d (d),
        .m1 (m1), .m2 (m2), .m3 (m3), .m4 (m4), .m5 (m5),
        .valid (valid), .error (error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (valid) nv++;
        if (error) ne++;
        if (valid && error) nboth++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] str2bits(input string s);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 5; i++) r[4-i] = (s[i] == "-");
        return r;
    endfunction

    function automatic int lookup(input logic [4:0] pat);
        for (int i = 0; i < 10; i++) if (str2bits(REF[i]) == pat) return i;
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic press(input int n);
        key = 1'b1;
        idle(n);
        key = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_abcd"}, {a, b, c, d}, exp_abcd);
        check({tag, "_m"}, {m1, m2, m3, m4, m5}, exp_m);
    endtask

    task automatic send_lens(input int lens[5], input int gap);
        logic [4:0] pat;
        int dig, k;
        bit seen;
        for (int i = 0; i < 5; i++) pat[4-i] = (lens[i] >= DOT_MAX);
        dig = lookup(pat);
        for (int i = 0; i < 5; i++) begin
            press(lens[i]);
            if (i < 4) idle(gap);
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clock); #1;
            k++;
            if (valid || error) seen = 1'b1;
        end
        check("pulse_seen", seen, 1);
        check("latency", k, 2 + LAT_EXTRA);
        check("valid", valid, dig >= 0);
        check("error", error, dig < 0);
        if (dig >= 0) begin
            exp_nv++;
            exp_abcd = 4'(dig);
            exp_m = pat;
        end else begin
            exp_ne++;
        end
        check_outputs("char");
        idle(15);
    endtask

    task automatic send_str(input string s);
        int l[5];
        for (int i = 0; i < 5; i++) l[i] = (s[i] == "-") ? 6 : 2;
        send_lens(l, 3);
    endtask

    initial begin
        int l[5];
        int k;
        bit seen;
        logic [4:0] pat;

        idle(2);
        reset = 1'b1;
        idle(1);
        check_outputs("reset");
        check("reset_valid", valid, 0);
        check("reset_error", error, 0);
        idle(20);
        check("idle_nv", nv, 0);
        check("idle_ne", ne, 0);

        for (int i = 1; i <= 10; i++) send_str(REF[i % 10]);

        l = '{3, 4, 6, 6, 6};
        send_lens(l, 3);

        send_str(".-.-.");

        press(2); idle(3); press(2); idle(3); press(2);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clock); #1;
            k++;
            if (valid || error) seen = 1'b1;
        end
        exp_ne++;
        check("gap_error", error, 1);
        check("gap_latency", k, GAP_CYCLES + LAT_EXTRA);
        check_outputs("gap");
        idle(5);
        send_str("--...");

        press(6); idle(3); press(2); idle(3);
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);
        exp_abcd = 4'd0;
        exp_m = 5'd0;
        check_outputs("midreset");
        send_str(".....");

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) pat = str2bits(REF[$urandom_range(0, 9)]);
            else                           pat = 5'($urandom);
            for (int i = 0; i < 5; i++)
                l[i] = pat[4-i] ? int'($urandom_range(DOT_MAX, DOT_MAX + 5))
                                : int'($urandom_range(1, DOT_MAX - 1));
            send_lens(l, int'($urandom_range(1, GAP_CYCLES - 1)));
        end

        check("total_valid", nv, exp_nv);
        check("total_error", ne, exp_ne);
        check("valid_and_error", nboth, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
